// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared types and constants for the instruction boot loader
// Contents: loader state enum, default frame start marker, frame field widths.
package instr_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;

    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/instr_loader.sv
// instr_loader: framed byte-stream boot loader writing the payload big-endian into instruction memory
// Ports:
//   Clock, Reset (async, active-high), Restart (sync return to IDLE)
//   InValid/InData/InReady : byte stream handshake, byte accepted when InValid && InReady
//   MemWrEn/MemAddr/MemData: registered one-cycle write to the byte-wide instruction memory
//   CpuHold                : holds the CPU until a frame has been loaded and verified
//   Done/Error             : registered frame outcome, held until Restart or Reset
// Build option: define INSTR_LOADER_CHECKSUM_EN to expect and verify a trailing CSUM byte;
// without it the frame ends after the payload and only the range check can raise Error.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int                MEM_BYTES = 128,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Restart,
    input  logic              InValid,
    input  logic [BYTE_W-1:0] InData,
    output logic              InReady,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [BYTE_W-1:0] MemData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error
);

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic [BYTE_W-1:0] csum;
    logic [BYTE_W-1:0] csum_next;
    logic [ADDR_W:0]   end_addr;
    logic              accept;

    assign InReady   = (state != DONE) && (state != ERROR);
    assign accept    = InValid && InReady;
    assign csum_next = csum + InData;
    // One extra bit so a start address near 16'hFFFF cannot wrap past the range check.
    assign end_addr  = {1'b0, addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, InData};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (Restart)
            state_next = IDLE;
        else if (accept)
            case (state)
                IDLE:    state_next = (InData == SYNC_BYTE) ? ADDR_HI : IDLE;
                ADDR_HI: state_next = ADDR_LO;
                ADDR_LO: state_next = LEN;
                LEN:     state_next = (end_addr > (ADDR_W + 1)'(MEM_BYTES)) ? ERROR :
                                      (InData == '0) ? AFTER_DATA : DATA;
                DATA:    state_next = (count == LEN_W'(1)) ? AFTER_DATA : DATA;
                CSUM:    state_next = (csum_next == '0) ? DONE : ERROR;
                default: state_next = state;
            endcase
    end

    // Outcome flags are registered from the next state so they rise one cycle after the
    // deciding byte, and CpuHold drops on exactly the same edge that raises Done.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            addr    <= '0;
            count   <= '0;
            csum    <= '0;
            MemWrEn <= 1'b0;
            MemAddr <= '0;
            MemData <= '0;
            CpuHold <= 1'b1;
            Done    <= 1'b0;
            Error   <= 1'b0;
        end else begin
            MemWrEn <= 1'b0;
            CpuHold <= state_next != DONE;
            Done    <= state_next == DONE;
            Error   <= state_next == ERROR;
            if (Restart)
                csum <= '0;
            else if (accept)
                case (state)
                    IDLE:    csum <= '0;
                    ADDR_HI: begin
                        addr[ADDR_W-1:BYTE_W] <= InData;
                        csum                  <= csum_next;
                    end
                    ADDR_LO: begin
                        addr[BYTE_W-1:0] <= InData;
                        csum             <= csum_next;
                    end
                    LEN:     begin
                        count <= InData;
                        csum  <= csum_next;
                    end
                    DATA:    begin
                        MemWrEn <= 1'b1;
                        MemAddr <= addr;
                        MemData <= InData;
                        addr    <= addr + ADDR_W'(1);
                        count   <= count - LEN_W'(1);
                        csum    <= csum_next;
                    end
                    default: ;
                endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: self-checking bench for instr_loader (directed table, corner sequences, random frames)
module tb_instr_loader;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;

    typedef struct {
        logic [95:0] v;
        int          n;
        int          gap;
        bit          done;
        bit          err;
        int          nwr;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Restart = 1'b0;
    logic        InValid = 1'b0;
    logic [7:0]  InData = 8'h00;
    logic        InReady;
    logic        MemWrEn;
    logic [15:0] MemAddr;
    logic [7:0]  MemData;
    logic        CpuHold;
    logic        Done;
    logic        Error;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    wr_t  got[$];
    wr_t  exp_w[$];
    bit   m_done, m_err;
    int   m_last;
    logic [7:0] dut_mem[128];
    logic [7:0] ref_mem[128];
    vec_t tbl[8];

    instr_loader dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Restart (Restart),
        .InValid (InValid),
        .InData  (InData),
        .InReady (InReady),
        .MemWrEn (MemWrEn),
        .MemAddr (MemAddr),
        .MemData (MemData),
        .CpuHold (CpuHold),
        .Done    (Done),
        .Error   (Error)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock)
        if (MemWrEn === 1'b1) begin
            got.push_back('{MemAddr, MemData, cyc});
            if (MemAddr < 16'd128)
                dut_mem[MemAddr] = MemData;
        end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: parse the stream as a frame and list the writes and outcome it must produce.
    task automatic model(input logic [7:0] s[$]);
        int i, a, len, sum, p;
        exp_w.delete();
        m_done = 0;
        m_err  = 0;
        m_last = s.size() - 1;
        i = 0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i + 3 >= s.size()) return;
        a   = {s[i+1], s[i+2]};
        len = s[i+3];
        sum = s[i+1] + s[i+2] + s[i+3];
        if (a + len > 128) begin
            m_err  = 1;
            m_last = i + 3;
            return;
        end
        for (int k = 0; k < len; k++) begin
            if (i + 4 + k >= s.size()) return;
            exp_w.push_back('{16'(a + k), s[i+4+k], i + 4 + k});
            sum += s[i+4+k];
        end
        p = i + 4 + len;
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (p >= s.size()) return;
        m_last = p;
        m_done = ((sum + s[p]) % 256) == 0;
        m_err  = !m_done;
`else
        m_last = p - 1;
        m_done = 1;
`endif
    endtask

    task automatic run(input logic [7:0] s[$], input int gap);
        int acc[64];
        int bad;
        model(s);
        got.delete();
        for (int i = 0; i <= m_last; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(1) == 1)) begin
                InValid = 1'b0;
                @(negedge Clock);
            end
            InValid = 1'b1;
            InData  = s[i];
            chk("in_ready", InReady, 1);
            acc[i] = cyc + 1;
            @(negedge Clock);
        end
        InValid = 1'b0;
        chk("done", Done, m_done);
        chk("error", Error, m_err);
        chk("cpu_hold", CpuHold, !m_done);
        chk("ready_term", InReady, !(m_done || m_err));
        @(negedge Clock);
        chk("wr_count", got.size(), exp_w.size());
        for (int j = 0; j < exp_w.size() && j < got.size(); j++)
            chk($sformatf("wr%0d addr/data/cycle", j), {got[j].a, got[j].d, 8'(got[j].c)},
                {exp_w[j].a, exp_w[j].d, 8'(acc[exp_w[j].c])});
        foreach (exp_w[j]) ref_mem[exp_w[j].a] = exp_w[j].d;
        bad = 0;
        for (int i = 0; i < 128; i++) if (dut_mem[i] !== ref_mem[i]) bad++;
        chk("mem_mismatches", bad, 0);
    endtask

    task automatic restart();
        Restart = 1'b1;
        @(negedge Clock);
        Restart = 1'b0;
        chk("rs_done", Done, 0);
        chk("rs_error", Error, 0);
        chk("rs_hold", CpuHold, 1);
        chk("rs_ready", InReady, 1);
    endtask

    task automatic to_q(input vec_t t, output logic [7:0] s[$]);
        s.delete();
        for (int j = 0; j < t.n; j++) s.push_back(8'(t.v >> (8 * (t.n - 1 - j))));
    endtask

    task automatic send_raw(input logic [7:0] s[$]);
        foreach (s[i]) begin
            InValid = 1'b1;
            InData  = s[i];
            @(negedge Clock);
        end
        InValid = 1'b0;
    endtask

    initial begin
        logic [7:0] s[$];
        logic [7:0] b, hi, lo, len, cs;
        int sum, g;
        for (int i = 0; i < 128; i++) begin
            dut_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        tbl[0] = '{96'hA5000A02C01024,     7, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{96'hA5000A02C01025,     7, 0, 1'b0, 1'b1, 2};
        tbl[2] = '{96'hA5007F02,           4, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{96'hA5007F01552B,       6, 0, 1'b1, 1'b0, 1};
        tbl[4] = '{96'h335AA5000A02C01024, 9, 0, 1'b1, 1'b0, 2};
        tbl[5] = '{96'hA5000A02C01024,     7, 1, 1'b1, 1'b0, 2};
        tbl[6] = '{96'hA5FFFF02,           4, 0, 1'b0, 1'b1, 0};
        tbl[7] = '{96'hA5000500FB,         5, 0, 1'b1, 1'b0, 0};
`else
        tbl[0] = '{96'hA5000A02C010,       6, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{96'hA50000019C,         5, 0, 1'b1, 1'b0, 1};
        tbl[2] = '{96'hA5007F02,           4, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{96'hA5007F0155,         5, 0, 1'b1, 1'b0, 1};
        tbl[4] = '{96'h335AA5000A02C010,   8, 0, 1'b1, 1'b0, 2};
        tbl[5] = '{96'hA5000A02C010,       6, 1, 1'b1, 1'b0, 2};
        tbl[6] = '{96'hA5FFFF02,           4, 0, 1'b0, 1'b1, 0};
        tbl[7] = '{96'hA5000500,           4, 0, 1'b1, 1'b0, 0};
`endif
        repeat (2) @(negedge Clock);
        chk("rst_ready", InReady, 1);
        chk("rst_wren", MemWrEn, 0);
        chk("rst_addr", MemAddr, 16'h0000);
        chk("rst_data", MemData, 8'h00);
        chk("rst_hold", CpuHold, 1);
        chk("rst_done", Done, 0);
        chk("rst_error", Error, 0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int t = 0; t < 8; t++) begin
            to_q(tbl[t], s);
            run(s, tbl[t].gap);
            chk($sformatf("tbl%0d_done", t), Done, tbl[t].done);
            chk($sformatf("tbl%0d_error", t), Error, tbl[t].err);
            chk($sformatf("tbl%0d_nwr", t), got.size(), tbl[t].nwr);
            restart();
        end

        // Asynchronous reset right after the first payload byte's write strobe appears.
        send_raw('{8'hA5, 8'h00, 8'h0A, 8'h02, 8'hC0});
        chk("mid_wren_before_reset", MemWrEn, 1);
        #1 Reset = 1'b1;
        #1;
        chk("mid_rst_wren", MemWrEn, 0);
        chk("mid_rst_addr", MemAddr, 16'h0000);
        chk("mid_rst_data", MemData, 8'h00);
        chk("mid_rst_hold", CpuHold, 1);
        chk("mid_rst_done", Done, 0);
        chk("mid_rst_error", Error, 0);
        chk("mid_rst_ready", InReady, 1);
        @(negedge Clock);
        Reset = 1'b0;
        got.delete();
        repeat (3) @(negedge Clock);
        chk("no_wr_after_reset", got.size(), 0);
        to_q(tbl[0], s);
        run(s, 0);
        restart();

        // Restart wins over a byte accepted in the same cycle.
        send_raw('{8'hA5, 8'h00, 8'h0A, 8'h02});
        got.delete();
        InValid = 1'b1;
        InData  = 8'h77;
        Restart = 1'b1;
        @(negedge Clock);
        Restart = 1'b0;
        InValid = 1'b0;
        chk("rp_wren", MemWrEn, 0);
        chk("rp_ready", InReady, 1);
        chk("rp_hold", CpuHold, 1);
        @(negedge Clock);
        chk("rp_no_wr", got.size(), 0);
        to_q(tbl[3], s);
        run(s, 0);
        restart();

        for (int r = 0; r < 40; r++) begin
            s.delete();
            g = $urandom_range(2);
            repeat (g) begin
                b = 8'($urandom_range(255));
                s.push_back(b == 8'hA5 ? 8'h00 : b);
            end
            hi  = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'h00;
            lo  = 8'($urandom_range(130));
            len = 8'($urandom_range(8));
            s.push_back(8'hA5);
            s.push_back(hi);
            s.push_back(lo);
            s.push_back(len);
            sum = hi + lo + len;
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom_range(255));
                s.push_back(b);
                sum += b;
            end
            cs = 8'(256 - (sum % 256));
            if ($urandom_range(3) == 0) cs = cs + 8'd1;
            s.push_back(cs);
            run(s, 2);
            restart();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot loader for the 16-bit CPU. It receives a framed byte stream over a valid/ready handshake and writes the payload big-endian into the byte-wide instruction memory, so programs can be loaded at run time instead of only from a file at elaboration. While loading, it holds the CPU through `CpuHold`, and releases it once a complete frame has been verified.

## Interface
- `MEM_BYTES`, default 128: size of the instruction memory in bytes; defines the legal address range 0..MEM_BYTES-1.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `Restart`  in  1  synchronous; returns the block to IDLE and re-asserts `CpuHold`.
- `InValid`  in  1  an input byte is present.
- `InData`  in  8  input byte.
- `InReady`  out  1  loader can accept a byte; decoded combinationally from state.
- `MemWrEn`  out  1  one-cycle write strobe to the instruction memory.
- `MemAddr`  out  16  byte address of the write.
- `MemData`  out  8  byte to write.
- `CpuHold`  out  1  high = CPU PC and register writes frozen.
- `Done`  out  1  frame loaded and verified.
- `Error`  out  1  frame rejected.

## Operation
- Frame format: SYNC, ADDR_HI, ADDR_LO, LEN, LEN payload bytes, CSUM.
- A byte is accepted on a rising `Clock` edge when `InValid && InReady`.
- States and transitions:
  - IDLE: wait for SYNC.
  - ADDR_HI, then ADDR_LO.
  - LEN.
  - DATA: repeated LEN times.
  - CSUM.
  - DONE and ERROR: terminal.
- IDLE: bytes other than `SYNC_BYTE` are consumed and discarded.
- LEN accepted:
  - If {ADDR_HI,ADDR_LO} + LEN > MEM_BYTES, go to ERROR. The sum is computed as 17 bits, so there is no wrap. No memory write occurs.
  - Otherwise, if LEN == 0, go to CSUM.
  - Otherwise, go to DATA.
- DATA: each accepted byte is written to the current address, and the address then increments by 1. Byte order in memory follows stream order: the high byte of an instruction sits at the even address.
- Checksum: an 8-bit running sum of ADDR_HI, ADDR_LO, LEN, the payload and CSUM, modulo 256, must equal 8'h00.
  - Pass: go to DONE.
  - Fail: go to ERROR. Bytes already written stay in memory.
- DONE: `Done`=1, `CpuHold`=0, `InReady`=0.
- ERROR: `Error`=1, `CpuHold`=1, `InReady`=0.
- DONE and ERROR are left only through `Restart` or `Reset`.
- `Restart` has priority over a simultaneously accepted byte; that byte is dropped. Restart clears `Done`, `Error` and the checksum, and sets `CpuHold`=1. It does not clear memory.

## Timing
- Reset values:
  - State: IDLE.
  - `InReady`=1.
  - `MemWrEn`=0, `MemAddr`=16'h0000, `MemData`=8'h00.
  - `CpuHold`=1, `Done`=0, `Error`=0.
- `MemWrEn`, `MemAddr` and `MemData` are registered. They are valid exactly one cycle after the payload byte is accepted, and `MemWrEn` is high for one cycle per byte.
- `Done` and `Error` are registered and assert one cycle after the deciding byte (CSUM or LEN) is accepted.
- `CpuHold` falls in the same cycle that `Done` rises.
- Throughput: one byte per cycle. `InReady` never drops mid-frame.
- If `Reset` is asserted mid-frame, all outputs return to their reset values immediately (asynchronously). A write strobe in flight is cancelled.

## Configuration
- `INSTR_LOADER_CHECKSUM_EN`
- Defined: the CSUM byte is expected and checked as described in Operation.
- Undefined: the frame carries no CSUM byte. The block goes from the last payload byte (or from LEN when LEN == 0) directly to DONE, and `Error` can only come from the range check.

## Structure
- Package `instr_loader_pkg` holds:
  - The state enum (IDLE, ADDR_HI, ADDR_LO, LEN, DATA, CSUM, DONE, ERROR).
  - The `SYNC_BYTE` default.
  - Frame field widths.
- No sub-module; the checksum accumulator and address counter are inline in a single FSM module.

## Test plan
- Valid frame A5 00 0A 02 C0 10 24 (sum 00+0A+02+C0+10+24=00) -> writes mem[10]=C0 and mem[11]=10 on consecutive cycles; `Done`=1 and `CpuHold`=0 one cycle after 24.
- Bad checksum A5 00 0A 02 C0 10 25 -> both bytes are written; `Error`=1 and `CpuHold` stays 1; a later `Restart` returns the block to IDLE with `Error`=0.
- Range A5 00 7F 02 ... -> `Error` is asserted after LEN with no `MemWrEn` pulse. LEN=01 at address 7F -> accepted, mem[127] written.
- Garbage 33 5A then a valid frame -> the leading bytes are discarded and the frame loads normally; `InValid` gapped every other cycle -> same memory contents.
- `Reset` pulse after the first payload byte -> all outputs at reset values and no further writes; a full frame afterwards succeeds.
- Macro undefined: A5 00 00 01 9C -> mem[0]=9C and `Done` asserted one cycle after 9C is accepted.
